// File: rtl/avalon_mm_arbiter_if.sv
// Avalon-MM bus bundle shared by both master ports and the slave port of avalon_mm_arbiter.
// The master modport drives the command side; the slave modport drives stall and read return.
interface avalon_mm_arbiter_if #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8
);
  localparam int DW = 8 * NBDATABYTES;

  logic [NBADDRBITS-1:0]  address;
  logic [NBDATABYTES-1:0] byteenable;
  logic [DW-1:0]          writedata;
  logic                   read;
  logic                   write;
  logic                   waitrequest;
  logic [DW-1:0]          readdata;
  logic                   readdatavalid;

  modport master (
    output address, byteenable, writedata, read, write,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, read, write,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mm_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter with pipelined read return via a pending-ID FIFO.
// Define AVALON_ARB_FIXED_PRIO_EN for fixed priority (m0 wins); default is round-robin.
module avalon_mm_arbiter #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int MAXPENDING  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_mm_arbiter_if.slave   m0,
  avalon_mm_arbiter_if.slave   m1,
  avalon_mm_arbiter_if.master  s,
  output logic                 err_rdv
);
  localparam int DW = 8 * NBDATABYTES;
  localparam int PW = $clog2(MAXPENDING);
  localparam logic [PW:0]   FULLCNT = (PW+1)'(MAXPENDING);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_gnt;
  logic [MAXPENDING-1:0] r_fifo;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;
  logic                  r_err_rdv;

  logic w_req0, w_req1, w_elig0, w_elig1;
  logic w_accept, w_push, w_pop, w_head_id;

  assign w_req0  = m0.read | m0.write;
  assign w_req1  = m1.read | m1.write;
  assign w_elig0 = m0.write | (m0.read & (r_count < FULLCNT));
  assign w_elig1 = m1.write | (m1.read & (r_count < FULLCNT));

  // Acceptance is derived from master inputs rather than s.read/s.write to keep the mux loop-free.
  assign w_accept = !s.waitrequest &
                    (((r_state == GNT0) & w_req0) | ((r_state == GNT1) & w_req1));
  assign w_push    = w_accept & (((r_state == GNT0) & m0.read) | ((r_state == GNT1) & m1.read));
  assign w_pop     = s.readdatavalid & (r_count != '0);
  assign w_head_id = r_fifo[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_accept)
        r_last_gnt <= (r_state == GNT1);
    end
  end

  always_comb begin
    w_next_state     = r_state;
    s.address        = {NBADDRBITS{1'b0}};
    s.byteenable     = {NBDATABYTES{1'b0}};
    s.writedata      = {DW{1'b0}};
    s.read           = 1'b0;
    s.write          = 1'b0;
    m0.waitrequest   = 1'b1;
    m1.waitrequest   = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_elig0 && w_elig1) begin
`ifdef AVALON_ARB_FIXED_PRIO_EN
          w_next_state = GNT0;
`else
          w_next_state = r_last_gnt ? GNT0 : GNT1;
`endif
        end else if (w_elig0) begin
          w_next_state = GNT0;
        end else if (w_elig1) begin
          w_next_state = GNT1;
        end
      end
      GNT0: begin
        s.address      = m0.address;
        s.byteenable   = m0.byteenable;
        s.writedata    = m0.writedata;
        s.read         = m0.read;
        s.write        = m0.write;
        m0.waitrequest = s.waitrequest;
        if (!w_req0 || w_accept)
          w_next_state = IDLE;
      end
      GNT1: begin
        s.address      = m1.address;
        s.byteenable   = m1.byteenable;
        s.writedata    = m1.writedata;
        s.read         = m1.read;
        s.write        = m1.write;
        m1.waitrequest = s.waitrequest;
        if (!w_req1 || w_accept)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Pending-read ID FIFO; pointers wrap naturally since MAXPENDING is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_rdv <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= (r_state == GNT1);
        r_wr_ptr         <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (s.readdatavalid && (r_count == '0))
        r_err_rdv <= 1'b1;
    end
  end

  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = w_pop & !w_head_id;
  assign m1.readdatavalid = w_pop & w_head_id;
  assign err_rdv          = r_err_rdv;
endmodule

// File: doc/avalon_mm_arbiter.md
Name: avalon_mm_arbiter

Overview:
Two-master to one-slave Avalon-MM arbiter with waitrequest flow control and pipelined reads (readdatavalid).
- Sits between two Avalon-MM masters (e.g. DMA and CPU bridge) and one shared slave.
- Grants the slave round-robin, one transfer at a time.
- Tracks outstanding reads in an ID FIFO so each readdatavalid beat returns to the master that issued it.

Parameters:
NBDATABYTES, 2, data bus width in bytes; data width DW = 8*NBDATABYTES, byteenable width NBDATABYTES
NBADDRBITS, 8, address width
MAXPENDING, 4, maximum outstanding accepted reads (power of 2, 2..16)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
m0_address/m1_address  in  NBADDRBITS  master address
m0_byteenable/m1_byteenable  in  NBDATABYTES  master byteenable
m0_writedata/m1_writedata  in  DW  master write data
m0_read/m1_read  in  1  master read request
m0_write/m1_write  in  1  master write request
m0_waitrequest/m1_waitrequest  out  1  stall to master
m0_readdata/m1_readdata  out  DW  read data to master
m0_readdatavalid/m1_readdatavalid  out  1  read data valid to master
s_address  out  NBADDRBITS  slave address
s_byteenable  out  NBDATABYTES  slave byteenable
s_writedata  out  DW  slave write data
s_read  out  1  slave read
s_write  out  1  slave write
s_waitrequest  in  1  slave stall
s_readdata  in  DW  slave read data
s_readdatavalid  in  1  slave read data valid
err_rdv  out  1  sticky: readdatavalid received with no pending read

Behaviour:
- FSM states: IDLE, GNT0, GNT1. State register is reset asynchronously to IDLE.
- Request: reqN = mN_read | mN_write.
- Eligibility: a read request is eligible only if pending < MAXPENDING. Write requests are always eligible.
- Arbitration in IDLE:
  - Only one master eligible: grant that master.
  - Both eligible: grant the master not served last (last_gnt register, reset = 1, so m0 wins first).
  - Grant is registered, so a command reaches the slave 1 cycle after the request appears.
- Command path in GNTn:
  - s_* = mn_* (combinational mux).
  - mn_waitrequest = s_waitrequest.
  - The other master's waitrequest = 1.
- Outside grant:
  - s_read = s_write = 0; s_address, s_byteenable, s_writedata = 0.
  - Both m*_waitrequest = 1.
- Transfer accepted: cycle where (s_read | s_write) & !s_waitrequest.
  - Next state = IDLE; last_gnt = n.
  - Minimum 2 cycles per transfer per master.
- Master drops its request while granted (protocol violation): return to IDLE next cycle, nothing pushed.
- Pending read FIFO:
  - Depth MAXPENDING, 1-bit master IDs, count 0..MAXPENDING.
  - Push granted ID on an accepted read.
  - Pop on s_readdatavalid.
  - Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo MAXPENDING.
- Read return (combinational):
  - On s_readdatavalid with FIFO non-empty: mK_readdatavalid = 1 for K = head ID.
  - m0_readdata = m1_readdata = s_readdata, always.
- Read return with FIFO empty: no master readdatavalid asserted, no pop, err_rdv set and held until reset.
- Full: a read request stays in wait (waitrequest = 1, not granted) until a readdatavalid frees a slot. A write from the other master may be granted in the meantime.
- Reset values: state IDLE, last_gnt 1, count 0, pointers 0, err_rdv 0, s_read/s_write 0, m*_waitrequest 1, m*_readdatavalid 0.
- Reset mid-transfer: all of the above apply immediately (asynchronous); in-flight read IDs are discarded.

Optional Feature:
AVALON_ARB_FIXED_PRIO_EN
- Defined: fixed priority; m0 always wins when both masters are eligible. last_gnt is still updated but ignored.
- Undefined: round-robin as specified above.

Test Plan:
- Single write: m0 write addr 0x12, data 0xBEEF, s_waitrequest=0 -> s_write=1 with 0x12/0xBEEF exactly 1 cycle after request; m0_waitrequest low that cycle; state back to IDLE next cycle.
- Contention: m0 and m1 request writes continuously -> grants alternate m0, m1, m0, m1; under AVALON_ARB_FIXED_PRIO_EN all grants go to m0 while m0 keeps requesting.
- Slave stall: m1 read, s_waitrequest=1 for 3 cycles -> s_address stable and m1_waitrequest=1 for 3 cycles; m0 request during the stall stays waiting; m1 read accepted on the 4th cycle.
- Pipelined reads: reads accepted m0, m1, m0; slave returns 3 readdatavalid beats D0, D1, D2 two cycles later -> m0 gets D0, m1 gets D1, m0 gets D2.
- Full FIFO: MAXPENDING=4, 4 reads accepted with no return -> 5th read held (waitrequest=1); a write from the other master is still granted; after one readdatavalid the held read is granted.
- Errors and reset: readdatavalid with count 0 -> err_rdv=1, no master valid. rst pulse mid-stall -> s_read=0 and err_rdv=0 asynchronously, count 0.
